// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RISC-V core: forwarding, load-use stall, branch flush,
// multi-cycle long-op stall sequencing with bubble injection, and saturating perf counters.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  ResultSrcE0,
    input  logic                  LongOpE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    input  logic                  ClrCnt,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  LongBusy,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam logic [3:0]            LAST_CNT = 4'(LONG_LAT - 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] cnt_r;
    logic       long_done_s;
    logic       long_stall_s;
    logic       lw_stall_s;
    logic       br_flush_s;

    // M stage wins over W when both hold the same destination; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Combinational hazard detection and pipeline control.
    always_comb begin
        long_done_s  = (cnt_r == LAST_CNT);
        long_stall_s = LongOpE && !long_done_s;
        lw_stall_s   = ResultSrcE0 && (RdE != REG_ZERO) &&
                       ((RdE == Rs1D) || (RdE == Rs2D)) && !long_stall_s;
        br_flush_s   = PCSrcE && !long_stall_s;

        StallF    = lw_stall_s | long_stall_s;
        StallD    = lw_stall_s | long_stall_s;
        StallE    = long_stall_s;
        FlushM    = long_stall_s;
        FlushD    = br_flush_s;
        FlushE    = lw_stall_s | br_flush_s;
        LongBusy  = long_stall_s;
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Long-op cycle counter: counts while E is held, returns to zero as the op advances.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            cnt_r <= 4'd0;
        end else if (long_stall_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= 4'd0;
        end
    end

    // Saturating performance counters; clear takes priority over counting.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            StallCycles <= CNT_ZERO;
            FlushCount  <= CNT_ZERO;
        end else if (ClrCnt) begin
            StallCycles <= CNT_ZERO;
            FlushCount  <= CNT_ZERO;
        end else begin
            if (StallF && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_ONE;
            end else begin
                StallCycles <= StallCycles;
            end
            if (br_flush_s && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end else begin
                FlushCount <= FlushCount;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (LONG_LAT=4, CNT_W=4).
module tb_hazard_scoreboard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       result_src_e0, long_op_e, pc_src_e, reg_write_m, reg_write_w, clr_cnt;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, long_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LONG_LAT(4), .CNT_W(4)) dut (
        .Clk(clk), .RstN(rst_n),
        .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
        .ResultSrcE0(result_src_e0), .LongOpE(long_op_e), .PCSrcE(pc_src_e),
        .RdM(rd_m), .RegWriteM(reg_write_m), .RdW(rd_w), .RegWriteW(reg_write_w),
        .ClrCnt(clr_cnt),
        .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
        .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m),
        .ForwardAE(fwd_a), .ForwardBE(fwd_b), .LongBusy(long_busy),
        .StallCycles(stall_cycles), .FlushCount(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0; result_src_e0 = 1'b0; long_op_e = 1'b0;
        pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_sc: got %0d expected 0", stall_cycles); end
        checks++;
        if (flush_count !== 4'd0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", flush_count); end
        checks++;
        if ({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, long_busy} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, long_busy});
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b}); end
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_tab [3];
        exp_tab[0] = 2'b10; exp_tab[1] = 2'b01; exp_tab[2] = 2'b00;
        reg_write_m = 1'b1; rd_m = 5'd5; reg_write_w = 1'b1; rd_w = 5'd5;
        rs1_e = 5'd5; rs2_e = 5'd5;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) rd_m = 5'd0;
            if (i == 2) rd_w = 5'd0;
            #1;
            checks++;
            if (fwd_a !== exp_tab[i]) begin errors++; $display("FAIL fwd_a[%0d]: got %b expected %b", i, fwd_a, exp_tab[i]); end
            checks++;
            if (fwd_b !== exp_tab[i]) begin errors++; $display("FAIL fwd_b[%0d]: got %b expected %b", i, fwd_b, exp_tab[i]); end
        end
        // Distinct sources: A from M, B from W.
        rd_m = 5'd3; rd_w = 5'd9; rs1_e = 5'd3; rs2_e = 5'd9;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1001) begin errors++; $display("FAIL fwd_split: got %b expected 1001", {fwd_a, fwd_b}); end
        reg_write_m = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_we_off: got %b expected 00", fwd_a); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        result_src_e0 = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        checks++;
        if ({stall_f, stall_d, flush_e, stall_e, flush_d} !== 5'b11100) begin
            errors++; $display("FAIL lw_ctrl: got %b expected 11100", {stall_f, stall_d, flush_e, stall_e, flush_d});
        end
        tick();
        exp_sc = 1;
        checks++;
        if (stall_cycles !== 4'(exp_sc)) begin errors++; $display("FAIL lw_sc: got %0d expected %0d", stall_cycles, exp_sc); end
        rd_e = 5'd0;
        #1;
        checks++;
        if ({stall_f, flush_e} !== 2'b00) begin errors++; $display("FAIL lw_x0: got %b expected 00", {stall_f, flush_e}); end
        clear_inputs();
    endtask

    task automatic test_long_op();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_sc = 0; exp_fc = 0;
        long_op_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({stall_f, stall_d, stall_e, flush_m, long_busy, flush_e} !== 6'b111110) begin
                errors++; $display("FAIL long_busy[%0d]: got %b expected 111110", i,
                    {stall_f, stall_d, stall_e, flush_m, long_busy, flush_e});
            end
            tick();
            exp_sc++;
        end
        checks++;
        if ({stall_f, stall_d, stall_e, flush_m, long_busy} !== 5'b00000) begin
            errors++; $display("FAIL long_done: got %b expected 00000",
                {stall_f, stall_d, stall_e, flush_m, long_busy});
        end
        tick();
        // Counter must have wrapped to 0 on the final cycle: a new op stalls again.
        checks++;
        if (long_busy !== 1'b1) begin errors++; $display("FAIL long_restart: got %b expected 1", long_busy); end
        long_op_e = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 4'(exp_sc)) begin errors++; $display("FAIL long_sc: got %0d expected %0d", stall_cycles, exp_sc); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_in_long();
        long_op_e = 1'b1;
        tick();
        exp_sc++;
        pc_src_e = 1'b1;
        #1;
        checks++;
        if ({flush_d, flush_e, long_busy} !== 3'b001) begin
            errors++; $display("FAIL br_in_long: got %b expected 001", {flush_d, flush_e, long_busy});
        end
        tick();
        exp_sc++;
        checks++;
        if (flush_count !== 4'(exp_fc)) begin errors++; $display("FAIL br_long_fc: got %0d expected %0d", flush_count, exp_fc); end
        long_op_e = 1'b0;
        #1;
        checks++;
        if ({flush_d, flush_e, stall_f} !== 3'b110) begin
            errors++; $display("FAIL br_flush: got %b expected 110", {flush_d, flush_e, stall_f});
        end
        tick();
        exp_fc++;
        pc_src_e = 1'b0;
        checks++;
        if (flush_count !== 4'(exp_fc)) begin errors++; $display("FAIL br_fc: got %0d expected %0d", flush_count, exp_fc); end
        checks++;
        if (stall_cycles !== 4'(exp_sc)) begin errors++; $display("FAIL br_sc: got %0d expected %0d", stall_cycles, exp_sc); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        result_src_e0 = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; pc_src_e = 1'b1;
        #1;
        checks++;
        if ({flush_d, flush_e, stall_f, stall_e} !== 4'b1110) begin
            errors++; $display("FAIL simul_ctrl: got %b expected 1110", {flush_d, flush_e, stall_f, stall_e});
        end
        tick();
        exp_sc++; exp_fc++;
        clear_inputs();
        checks++;
        if ({stall_cycles, flush_count} !== {4'(exp_sc), 4'(exp_fc)}) begin
            errors++; $display("FAIL simul_cnt: got %0d/%0d expected %0d/%0d", stall_cycles, flush_count, exp_sc, exp_fc);
        end
    endtask

    task automatic test_saturation();
        result_src_e0 = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
        end
        checks++;
        if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_sc: got %0d expected 15", stall_cycles); end
        clr_cnt = 1'b1;
        tick();
        exp_sc = 0; exp_fc = 0;
        checks++;
        if ({stall_cycles, flush_count} !== 8'd0) begin
            errors++; $display("FAIL clr_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        long_op_e = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        exp_sc = 0; exp_fc = 0;
        checks++;
        if ({stall_cycles, flush_count} !== 8'd0) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (long_busy !== 1'b1) begin errors++; $display("FAIL rst_restart[%0d]: got %b expected 1", i, long_busy); end
            tick();
            exp_sc++;
        end
        checks++;
        if (long_busy !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", long_busy); end
        long_op_e = 1'b0;
        tick();
        checks++;
        if (stall_cycles !== 4'(exp_sc)) begin errors++; $display("FAIL rst_sc: got %0d expected %0d", stall_cycles, exp_sc); end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_op();
        test_branch_in_long();
        test_simultaneous();
        test_saturation();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the pipeline's hazard unit, for the 5-stage RISC-V core. Adds the following to the existing forwarding, load-use stall and branch flush:
- a multi-cycle execute (long-op) stall sequencer with configurable latency;
- bubble injection into M while a long op runs;
- saturating stall and flush performance counters.

Sits beside DataPath and Controller; drives the stall, flush and forward controls.

Parameters:
REG_ADDR_W, 5, register index width
LONG_LAT, 4, cycles a long op (mul/div) occupies E; legal range 1..15; 1 means no stall
CNT_W, 16, width of the performance counters

Ports:
Clk  input  1  clock, rising edge
RstN  input  1  synchronous active-low reset
Rs1D  input  REG_ADDR_W  decode-stage source 1
Rs2D  input  REG_ADDR_W  decode-stage source 2
Rs1E  input  REG_ADDR_W  execute-stage source 1
Rs2E  input  REG_ADDR_W  execute-stage source 2
RdE  input  REG_ADDR_W  execute-stage destination
ResultSrcE0  input  1  E instruction is a load
LongOpE  input  1  E instruction is a long op; held stable while E is stalled
PCSrcE  input  1  taken branch or jump resolved in E
RdM  input  REG_ADDR_W  memory-stage destination
RegWriteM  input  1  M writes the register file
RdW  input  REG_ADDR_W  writeback-stage destination
RegWriteW  input  1  W writes the register file
ClrCnt  input  1  synchronous clear of the performance counters
StallF  output  1  hold PC
StallD  output  1  hold IF/ID
StallE  output  1  hold ID/EX
FlushD  output  1  clear IF/ID
FlushE  output  1  clear ID/EX
FlushM  output  1  clear EX/MEM (bubble)
ForwardAE  output  2  00 = register file, 01 = W result, 10 = M ALU result
ForwardBE  output  2  same encoding as ForwardAE, for source 2
LongBusy  output  1  long-op stall in progress
StallCycles  output  CNT_W  saturating count of cycles with StallF=1
FlushCount  output  CNT_W  saturating count of branch flushes

Behaviour:
- State is held in three registers: long counter cnt (4 bits), StallCycles, FlushCount. All reset to 0 on Clk edge when RstN=0. Every other output is combinational.
- Forwarding, source 1:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - M has priority over W.
- Forwarding, source 2: ForwardBE follows the same rules using Rs2E.
- Long-op sequencing:
  - longDone = (cnt == LONG_LAT-1).
  - longStall = LongOpE && !longDone.
  - Next cnt = cnt+1 if longStall, else 0.
  - A long op therefore stays in E for exactly LONG_LAT cycles and advances on the last one.
  - LongBusy = longStall.
- Load-use hazard: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !longStall.
- Branch: brFlush = PCSrcE && !longStall.
- Stall and flush outputs:
  - StallF = StallD = lwStall | longStall.
  - StallE = longStall.
  - FlushM = longStall.
  - FlushD = brFlush.
  - FlushE = lwStall | brFlush.
  - FlushE is never asserted during longStall, so the long op is never killed.
- Simultaneous lwStall and brFlush: both apply, so FlushD=1, FlushE=1, StallF=1. StallF is ignored by the PC mux when the branch is taken.
- Counters:
  - ClrCnt has priority and zeroes both counters on the next edge.
  - Otherwise StallCycles increments when StallF=1, and FlushCount increments when brFlush=1.
  - Both saturate at 2^CNT_W-1; they never wrap.
- Reset mid long-op: cnt returns to 0. If LongOpE is still asserted after reset release, the op restarts a full LONG_LAT sequence.
- Latency: all stall, flush and forward outputs are zero-cycle (combinational on the current inputs). Counters update on the following edge.

Test Plan:
- Forwarding priority: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=5 -> ForwardAE=10, ForwardBE=10. Change RdM=0 -> both become 01. Change RdW=0 also -> both become 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0, StallCycles +1 next edge. Change RdE=0 -> no stall.
- Long op, LONG_LAT=4: hold LongOpE=1 -> StallF/D/E, FlushM and LongBusy high for 3 cycles with cnt 0,1,2. Cycle 4 all low; cnt back to 0. StallCycles=3.
- Branch during long op: LongOpE=1, cnt=1, PCSrcE=1 -> FlushD=FlushE=0, FlushCount unchanged. LongOpE=0, PCSrcE=1 -> FlushD=FlushE=1, FlushCount +1.
- Saturation and clear: CNT_W=4, 20 consecutive stall cycles -> StallCycles=15. Then ClrCnt=1 with stall still active -> StallCycles=0 next edge.
- Reset mid-op: RstN=0 while cnt=2 -> cnt=0 and counters 0. After release with LongOpE=1 -> 3 further stall cycles (LONG_LAT=4).
